// File: rtl/tft_spi_tx.sv
// Byte-wide SPI mode-0 transmitter for the TFT panel: MSB-first shift with a D/C
// qualifier, and chip select held low across back-to-back bytes.
module tft_spi_tx #(
  parameter int CLK_DIV = 2,
  parameter int CS_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic [7:0] tft_data,
  input  logic       tft_dc,
  output logic       tft_busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_dc,
  output logic       spi_cs_n
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = (CS_HOLD == 0) ? 8'd0 : 8'(CS_HOLD - 1);
  localparam bit         HOLD_ZERO = (CS_HOLD == 0);

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] hold_q, hold_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       dc_q, dc_d;
  logic       cs_n_q, cs_n_d;
  logic       busy_q, busy_d;
  logic       req;

  assign req = tft_transmit && !busy_q;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    hold_d  = hold_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    dc_d    = dc_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE, HOLD: begin
        if (req) begin
          // Accepting in HOLD keeps CS low so a pixel stream stays one burst.
          state_d = SHIFT;
          sr_d    = tft_data;
          mosi_d  = tft_data[7];
          dc_d    = tft_dc;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sck_d   = 1'b0;
          div_d   = 8'd0;
          bit_d   = 4'd0;
          hold_d  = 8'd0;
        end else if (state_q == HOLD) begin
          if (hold_q == HOLD_LAST) begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (!sck_q) begin
            sck_d = 1'b1;
            bit_d = bit_q + 4'd1;
          end else begin
            // Falling edge: next bit goes out a full half-period before the rise.
            sck_d  = 1'b0;
            sr_d   = {sr_q[6:0], 1'b0};
            mosi_d = sr_q[6];
            if (bit_q == 4'd8) begin
              busy_d = 1'b0;
              bit_d  = 4'd0;
              hold_d = 8'd0;
              if (HOLD_ZERO) begin
                state_d = IDLE;
                cs_n_d  = 1'b1;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 8'd0;
      div_q   <= 8'd0;
      bit_q   <= 4'd0;
      hold_q  <= 8'd0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      dc_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
    end
  end

  assign tft_busy = busy_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_dc   = dc_q;
  assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_tft_spi_tx.sv
// Directed bench: u0 uses CLK_DIV=2/CS_HOLD=4, u1 uses CLK_DIV=1/CS_HOLD=0.
module tb_tft_spi_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       t0, t1;
  logic [7:0] d0, d1;
  logic       c0, c1;
  logic       b0, sck0, mosi0, dc0, cs0;
  logic       b1, sck1, mosi1, dc1, cs1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tft_spi_tx #(.CLK_DIV(2), .CS_HOLD(4)) u0 (
    .clk(clk), .rst(rst), .tft_transmit(t0), .tft_data(d0), .tft_dc(c0),
    .tft_busy(b0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_dc(dc0), .spi_cs_n(cs0));

  tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(0)) u1 (
    .clk(clk), .rst(rst), .tft_transmit(t1), .tft_data(d1), .tft_dc(c1),
    .tft_busy(b1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_dc(dc1), .spi_cs_n(cs1));

  // Wire-side monitors: free-running histories, tests work on deltas.
  int          edges0 = 0, edges1 = 0, csr0 = 0;
  logic [31:0] rx0 = '0, dch0 = '0, rx1 = '0;

  always @(posedge sck0) begin
    edges0 <= edges0 + 1;
    rx0    <= {rx0[30:0], mosi0};
    dch0   <= {dch0[30:0], dc0};
  end
  always @(posedge sck1) begin
    edges1 <= edges1 + 1;
    rx1    <= {rx1[30:0], mosi1};
  end
  always @(posedge cs0) csr0 <= csr0 + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_free0(input string name);
    int n = 0;
    while (b0 === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Waits for a free slot (so a burst request lands the cycle busy falls), pulses once.
  task automatic send0(input logic [7:0] data, input logic dc);
    wait_free0("send0");
    t0 = 1'b1; d0 = data; c0 = dc;
    @(negedge clk);
    t0 = 1'b0; d0 = 8'h00; c0 = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic [7:0] exp_rx;
    logic [7:0] exp_dch;
    int         exp_busy;
    int         exp_cs_rise;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int e0, e1, r0, busy_n, cs_at, k;
    logic cs_k16, b_k17, cs_k17;

    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 8'hFF, 32, 37};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 8'h00, 32, 37};
    vecs[2] = '{8'h80, 1'b1, 8'h80, 8'hFF, 32, 37};
    vecs[3] = '{8'h01, 1'b0, 8'h01, 8'h00, 32, 37};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF, 8'hFF, 32, 37};

    rst = 1'b1; t0 = 1'b0; t1 = 1'b0; d0 = '0; d1 = '0; c0 = 1'b0; c1 = 1'b0;
    wait_cycles(3);
    chk("rst_busy", {31'd0, b0}, 32'd0);
    chk("rst_sck", {31'd0, sck0}, 32'd0);
    chk("rst_mosi", {31'd0, mosi0}, 32'd0);
    chk("rst_dc", {31'd0, dc0}, 32'd0);
    chk("rst_cs", {31'd0, cs0}, 32'd1);
    chk("rst_cs_u1", {31'd0, cs1}, 32'd1);
    rst = 1'b0;
    wait_cycles(6);

    // Single bytes: index k of the negedge after the request cycle is cycle T+k.
    for (int v = 0; v < 5; v++) begin
      e0 = edges0;
      busy_n = 0; cs_at = 0;
      t0 = 1'b1; d0 = vecs[v].data; c0 = vecs[v].dc;
      for (int j = 1; j <= 45; j++) begin
        @(negedge clk);
        if (j == 1) begin t0 = 1'b0; d0 = '0; c0 = 1'b0; end
        if (b0) busy_n++;
        if (j == 1) chk($sformatf("v%0d_cs_fall", v), {31'd0, cs0}, 32'd0);
        if (cs0 && cs_at == 0) cs_at = j;
      end
      chk($sformatf("v%0d_edges", v), 32'(edges0 - e0), 32'd8);
      chk($sformatf("v%0d_rx", v), {24'd0, rx0[7:0]}, {24'd0, vecs[v].exp_rx});
      chk($sformatf("v%0d_dc", v), {24'd0, dch0[7:0]}, {24'd0, vecs[v].exp_dch});
      chk($sformatf("v%0d_busy_cyc", v), 32'(busy_n), 32'(vecs[v].exp_busy));
      chk($sformatf("v%0d_cs_rise", v), 32'(cs_at), 32'(vecs[v].exp_cs_rise));
      wait_cycles(3);
    end

    // Burst: second request issued in the cycle busy falls.
    e0 = edges0; r0 = csr0;
    send0(8'h2C, 1'b0);
    send0(8'hFF, 1'b1);
    wait_free0("burst");
    chk("burst_edges", 32'(edges0 - e0), 32'd16);
    chk("burst_rx", {16'd0, rx0[15:0]}, 32'h2CFF);
    chk("burst_dc", {16'd0, dch0[15:0]}, 32'h00FF);
    chk("burst_cs_low", 32'(csr0 - r0), 32'd0);
    chk("burst_cs_now", {31'd0, cs0}, 32'd0);
    wait_cycles(10);
    chk("burst_cs_end", 32'(csr0 - r0), 32'd1);

    // Request while busy is dropped.
    e0 = edges0;
    send0(8'h81, 1'b1);
    wait_cycles(3);
    t0 = 1'b1; d0 = 8'h00; c0 = 1'b0;
    @(negedge clk);
    t0 = 1'b0;
    wait_free0("ign");
    wait_cycles(60);
    chk("ign_edges", 32'(edges0 - e0), 32'd8);
    chk("ign_rx", {24'd0, rx0[7:0]}, 32'h81);

    // Reset right after the 3rd rising edge.
    e0 = edges0;
    send0(8'hC3, 1'b1);
    k = 0;
    while ((edges0 - e0) < 3 && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) chk("rstmid_timeout", 32'd1, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_cs", {31'd0, cs0}, 32'd1);
    chk("rstmid_sck", {31'd0, sck0}, 32'd0);
    chk("rstmid_mosi", {31'd0, mosi0}, 32'd0);
    chk("rstmid_busy", {31'd0, b0}, 32'd0);
    chk("rstmid_dc", {31'd0, dc0}, 32'd0);
    rst = 1'b0;
    wait_cycles(2);
    e0 = edges0;
    send0(8'h5A, 1'b0);
    wait_free0("after_rst");
    chk("after_rst_edges", 32'(edges0 - e0), 32'd8);
    chk("after_rst_rx", {24'd0, rx0[7:0]}, 32'h5A);
    wait_cycles(10);

    // Scene-exhibitor style stream: zero pixels, dc=1, one CS burst.
    e0 = edges0; r0 = csr0;
    send0(8'h00, 1'b1);
    send0(8'h00, 1'b1);
    send0(8'h00, 1'b1);
    wait_free0("stream");
    chk("stream_edges", 32'(edges0 - e0), 32'd24);
    chk("stream_rx", {8'd0, rx0[23:0]}, 32'h0);
    chk("stream_dc", {8'd0, dch0[23:0]}, 32'h00FF_FFFF);
    chk("stream_cs_low", 32'(csr0 - r0), 32'd0);
    wait_cycles(10);

    // CLK_DIV=1, CS_HOLD=0: 16 busy cycles, CS rises as busy drops.
    e1 = edges1; busy_n = 0; cs_k16 = 1'b1; b_k17 = 1'b1; cs_k17 = 1'b0;
    t1 = 1'b1; d1 = 8'h96; c1 = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin t1 = 1'b0; d1 = '0; c1 = 1'b0; end
      if (b1) busy_n++;
      if (j == 16) cs_k16 = cs1;
      if (j == 17) begin b_k17 = b1; cs_k17 = cs1; end
    end
    chk("d1_busy_cyc", 32'(busy_n), 32'd16);
    chk("d1_cs_k16", {31'd0, cs_k16}, 32'd0);
    chk("d1_busy_k17", {31'd0, b_k17}, 32'd0);
    chk("d1_cs_k17", {31'd0, cs_k17}, 32'd1);
    chk("d1_edges", 32'(edges1 - e1), 32'd8);
    chk("d1_rx", {24'd0, rx1[7:0]}, 32'h96);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
